lut3d_table_writer: RTL and testbench

- Writer side of the 3x3x3 event-control lookup table.
- Owns the table storage and fills it through two paths: single indexed writes, or an auto-incrementing burst load.
- Provides a registered read port that the event-control partition logic uses in place of a constant parameter array.
- Also supports a sequential clear sweep.

---
 rtl/lut3d_pkg.sv | 23 ++
 rtl/lut3d_idx_counter.sv | 66 ++++++
 rtl/lut3d_table_writer.sv | 178 +++++++++++++++++
 tb/tb_lut3d_table_writer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lut3d_pkg.sv
// Shared types and index helpers for the 3-D event-control lookup table.
// The state enum and the range/flat-address functions are used by the writer and its counter.
package lut3d_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    localparam int DIM_DEFAULT = 3;

    function automatic logic idx_valid(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned dim);
        return (a < dim) && (b < dim) && (c < dim);
    endfunction

    function automatic int unsigned flat_addr(input int unsigned a, input int unsigned b,
                                              input int unsigned c, input int unsigned dim);
        return a * dim * dim + b * dim + c;
    endfunction

endpackage

// File: rtl/lut3d_idx_counter.sv
// Three-digit base-DIM counter (c is the least significant digit) shared by burst and clear.
// clr_i dominates inc_i; the final increment wraps all digits back to (0,0,0).
module lut3d_idx_counter
    import lut3d_pkg::*;
#(
    parameter int DIM = DIM_DEFAULT,
    localparam int IDX_W = $clog2(DIM)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [IDX_W-1:0] a_o,
    output logic [IDX_W-1:0] b_o,
    output logic [IDX_W-1:0] c_o,
    output logic             last_o
);

    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(DIM - 1);
    localparam logic [IDX_W-1:0] ONE     = IDX_W'(1);

    logic [IDX_W-1:0] a_q, b_q, c_q;
    logic [IDX_W-1:0] a_d, b_d, c_d;

    // Digits are not powers of two in general, so each wrap is explicit.
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        c_d = c_q;
        if (clr_i) begin
            a_d = '0;
            b_d = '0;
            c_d = '0;
        end else if (inc_i) begin
            if (c_q == MAX_IDX) begin
                c_d = '0;
                if (b_q == MAX_IDX) begin
                    b_d = '0;
                    a_d = (a_q == MAX_IDX) ? '0 : a_q + ONE;
                end else begin
                    b_d = b_q + ONE;
                end
            end else begin
                c_d = c_q + ONE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_q <= '0;
            b_q <= '0;
            c_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            c_q <= c_d;
        end
    end

    assign a_o    = a_q;
    assign b_o    = b_q;
    assign c_o    = c_q;
    assign last_o = (a_q == MAX_IDX) && (b_q == MAX_IDX) && (c_q == MAX_IDX);

endmodule

// File: rtl/lut3d_table_writer.sv
// Owns the DIM^3 event-control table: single indexed writes, auto-increment burst loads,
// a one-entry-per-cycle clear sweep, and a registered read port with range flagging.
module lut3d_table_writer
    import lut3d_pkg::*;
#(
    parameter int DATA_W = 1,
    parameter int DIM    = DIM_DEFAULT,
    localparam int IDX_W = $clog2(DIM)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_valid_i,
    output logic              wr_ready_o,
    input  logic [IDX_W-1:0]  wr_a_i,
    input  logic [IDX_W-1:0]  wr_b_i,
    input  logic [IDX_W-1:0]  wr_c_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              burst_go_i,
    input  logic              burst_abort_i,
    input  logic              clr_req_i,
    input  logic [IDX_W-1:0]  rd_a_i,
    input  logic [IDX_W-1:0]  rd_b_i,
    input  logic [IDX_W-1:0]  rd_c_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_err_o,
    output logic              wr_err_o,
    output logic              done_o,
    output logic              busy_o
);

    localparam int DEPTH  = DIM * DIM * DIM;
    localparam int ADDR_W = $clog2(DEPTH);

    state_t            state_q;
    logic              busy_q;
    logic              done_q;
    logic              wr_err_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_err_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [IDX_W-1:0]  cnt_a, cnt_b, cnt_c;
    logic              cnt_last;
    logic              cnt_inc;
    logic              cnt_clr;

    logic              accept;
    logic              single_ok;
    logic              rd_ok;
    logic              we;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] wr_value;

    lut3d_idx_counter #(.DIM(DIM)) u_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .inc_i  (cnt_inc),
        .clr_i  (cnt_clr),
        .a_o    (cnt_a),
        .b_o    (cnt_b),
        .c_o    (cnt_c),
        .last_o (cnt_last)
    );

    // Write-side steering: addresses are flattened only once the indices are known in range.
    always_comb begin
        single_ok = idx_valid(32'(wr_a_i), 32'(wr_b_i), 32'(wr_c_i), DIM);
        rd_ok     = idx_valid(32'(rd_a_i), 32'(rd_b_i), 32'(rd_c_i), DIM);
        rd_addr   = rd_ok ? ADDR_W'(flat_addr(32'(rd_a_i), 32'(rd_b_i), 32'(rd_c_i), DIM)) : '0;
        wr_ready_o = 1'b0;
        we        = 1'b0;
        wr_addr   = '0;
        wr_value  = wr_data_i;
        cnt_inc   = 1'b0;
        cnt_clr   = 1'b0;
        case (state_q)
            S_IDLE: begin
                wr_ready_o = !clr_req_i && !burst_go_i;
                cnt_clr    = 1'b1;
                if (wr_valid_i && wr_ready_o && single_ok) begin
                    we      = 1'b1;
                    wr_addr = ADDR_W'(flat_addr(32'(wr_a_i), 32'(wr_b_i), 32'(wr_c_i), DIM));
                end
            end
            S_BURST: begin
                wr_ready_o = 1'b1;
                we         = wr_valid_i;
                wr_addr    = ADDR_W'(flat_addr(32'(cnt_a), 32'(cnt_b), 32'(cnt_c), DIM));
                cnt_inc    = wr_valid_i;
                cnt_clr    = burst_abort_i;
            end
            S_CLEAR: begin
                we       = 1'b1;
                wr_addr  = ADDR_W'(flat_addr(32'(cnt_a), 32'(cnt_b), 32'(cnt_c), DIM));
                wr_value = '0;
                cnt_inc  = 1'b1;
            end
            default: cnt_clr = 1'b1;
        endcase
        accept = wr_valid_i && wr_ready_o;
    end

    // Control FSM; busy, done and wr_err are registered alongside the state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            wr_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (clr_req_i) begin
                        state_q <= S_CLEAR;
                        busy_q  <= 1'b1;
                    end else if (burst_go_i) begin
                        state_q <= S_BURST;
                        busy_q  <= 1'b1;
                    end else if (accept && !single_ok) begin
                        wr_err_q <= 1'b1;
                    end
                end
                S_BURST: begin
                    if (burst_abort_i) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (accept && cnt_last) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (cnt_last) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[wr_addr] <= wr_value;
        end
    end

    // Reads sample the pre-edge contents, so a same-cycle write is seen one read later.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
            rd_err_q  <= 1'b0;
        end else begin
            rd_data_q <= rd_ok ? mem_q[rd_addr] : '0;
            rd_err_q  <= !rd_ok;
        end
    end

    assign rd_data_o = rd_data_q;
    assign rd_err_o  = rd_err_q;
    assign wr_err_o  = wr_err_q;
    assign done_o    = done_q;
    assign busy_o    = busy_q;

endmodule

// File: tb/tb_lut3d_table_writer.sv
// Directed bench for lut3d_table_writer: a vector table of single writes/reads plus
// hand-written burst, abort, clear and reset-mid-clear sequences against a bench-side model.
module tb_lut3d_table_writer;

    logic       clk_i;
    logic       rst_i;
    logic       wr_valid_i;
    logic       wr_ready_o;
    logic [1:0] wr_a_i, wr_b_i, wr_c_i;
    logic       wr_data_i;
    logic       burst_go_i;
    logic       burst_abort_i;
    logic       clr_req_i;
    logic [1:0] rd_a_i, rd_b_i, rd_c_i;
    logic       rd_data_o;
    logic       rd_err_o;
    logic       wr_err_o;
    logic       done_o;
    logic       busy_o;

    int passCount;
    int totalCount;
    bit model [27];

    typedef struct {
        string      name;
        logic       wr;
        logic [1:0] a, b, c;
        logic       d;
        logic       expOld;
        logic       expNew;
        logic       expErr;
        logic       expWrErr;
    } vec_t;

    vec_t vecs [8];

    lut3d_table_writer dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .wr_valid_i    (wr_valid_i),
        .wr_ready_o    (wr_ready_o),
        .wr_a_i        (wr_a_i),
        .wr_b_i        (wr_b_i),
        .wr_c_i        (wr_c_i),
        .wr_data_i     (wr_data_i),
        .burst_go_i    (burst_go_i),
        .burst_abort_i (burst_abort_i),
        .clr_req_i     (clr_req_i),
        .rd_a_i        (rd_a_i),
        .rd_b_i        (rd_b_i),
        .rd_c_i        (rd_c_i),
        .rd_data_o     (rd_data_o),
        .rd_err_o      (rd_err_o),
        .wr_err_o      (wr_err_o),
        .done_o        (done_o),
        .busy_o        (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic vec_t mkVec(string n, logic wr, logic [1:0] a, logic [1:0] b, logic [1:0] c,
                                   logic d, logic eo, logic en, logic ee, logic ew);
        vec_t v;
        v.name = n; v.wr = wr; v.a = a; v.b = b; v.c = c; v.d = d;
        v.expOld = eo; v.expNew = en; v.expErr = ee; v.expWrErr = ew;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic act, input logic exp);
        totalCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got %0b, expected %0b", name, act, exp);
    endtask

    task automatic applyStimulus(input logic wv, input logic [1:0] a, input logic [1:0] b,
                                 input logic [1:0] c, input logic d, input logic bg,
                                 input logic ba, input logic cr);
        wr_valid_i = wv; wr_a_i = a; wr_b_i = b; wr_c_i = c; wr_data_i = d;
        burst_go_i = bg; burst_abort_i = ba; clr_req_i = cr;
    endtask

    task automatic setIdle();
        applyStimulus(1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic setRead(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
        rd_a_i = a; rd_b_i = b; rd_c_i = c;
    endtask

    task automatic readCheck(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c,
                             input logic expData, input logic expErr, input string name);
        setRead(a, b, c);
        tick();
        checkOutput({name, "_data"}, rd_data_o, expData);
        checkOutput({name, "_err"}, rd_err_o, expErr);
    endtask

    task automatic sweepCheck(input string name);
        for (int idx = 0; idx < 27; idx++) begin
            readCheck(2'(idx / 9), 2'((idx / 3) % 3), 2'(idx % 3), model[idx], 1'b0,
                      $sformatf("%s_%0d", name, idx));
        end
    endtask

    // mode 0 loads flat-index parity, mode 1 loads all ones; pauseAt < 0 means no stall.
    task automatic runBurst(input int pauseAt, input int mode, input string name);
        logic d;
        applyStimulus(1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput({name, "_go_ready"}, wr_ready_o, 1'b0);
        tick();
        checkOutput({name, "_go_busy"}, busy_o, 1'b1);
        for (int i = 0; i < 27; i++) begin
            if (i == pauseAt) begin
                for (int p = 0; p < 2; p++) begin
                    setIdle();
                    tick();
                    checkOutput($sformatf("%s_stall_busy%0d", name, p), busy_o, 1'b1);
                    checkOutput($sformatf("%s_stall_done%0d", name, p), done_o, 1'b0);
                end
            end
            d = (mode == 1) ? 1'b1 : 1'(i & 1);
            applyStimulus(1'b1, 2'd3, 2'd3, 2'd3, d, 1'b0, 1'b0, 1'b0);
            #1;
            checkOutput($sformatf("%s_ready%0d", name, i), wr_ready_o, 1'b1);
            tick();
            model[i] = d;
            checkOutput($sformatf("%s_done%0d", name, i), done_o, (i == 26) ? 1'b1 : 1'b0);
            checkOutput($sformatf("%s_busy%0d", name, i), busy_o, (i == 26) ? 1'b0 : 1'b1);
        end
        setIdle();
        tick();
        checkOutput({name, "_done_after"}, done_o, 1'b0);
    endtask

    // rstAt < 0 lets the sweep finish; otherwise reset is pulsed at that clear cycle.
    task automatic runClear(input int rstAt, input string name);
        applyStimulus(1'b1, 2'd0, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        #1;
        checkOutput({name, "_req_ready"}, wr_ready_o, 1'b0);
        tick();
        checkOutput({name, "_busy_start"}, busy_o, 1'b1);
        setRead(2'd2, 2'd2, 2'd2);
        for (int k = 0; k < 27; k++) begin
            applyStimulus(1'b1, 2'd1, 2'd1, 2'd1, 1'b1, 1'b1, 1'b1, 1'b1);
            #1;
            checkOutput($sformatf("%s_ready%0d", name, k), wr_ready_o, 1'b0);
            if (k == rstAt) begin
                rst_i = 1'b1;
                tick();
                rst_i = 1'b0;
                setIdle();
                for (int j = 0; j < 27; j++) model[j] = 1'b0;
                checkOutput({name, "_rst_busy"}, busy_o, 1'b0);
                checkOutput({name, "_rst_done"}, done_o, 1'b0);
                checkOutput({name, "_rst_rd"}, rd_data_o, 1'b0);
                #1;
                checkOutput({name, "_rst_wr_ready"}, wr_ready_o, 1'b1);
                for (int q = 0; q < 3; q++) begin
                    tick();
                    checkOutput($sformatf("%s_rst_quiet%0d", name, q), done_o, 1'b0);
                end
                return;
            end
            tick();
            checkOutput($sformatf("%s_done%0d", name, k), done_o, (k == 26) ? 1'b1 : 1'b0);
            checkOutput($sformatf("%s_busy%0d", name, k), busy_o, (k == 26) ? 1'b0 : 1'b1);
        end
        setIdle();
        for (int j = 0; j < 27; j++) model[j] = 1'b0;
        tick();
        checkOutput({name, "_done_after"}, done_o, 1'b0);
        checkOutput({name, "_busy_after"}, busy_o, 1'b0);
    endtask

    initial begin
        passCount  = 0;
        totalCount = 0;
        for (int j = 0; j < 27; j++) model[j] = 1'b0;

        vecs[0] = mkVec("w120",  1'b1, 2'd1, 2'd2, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[1] = mkVec("r121",  1'b0, 2'd1, 2'd2, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[2] = mkVec("w300",  1'b1, 2'd3, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        vecs[3] = mkVec("r030",  1'b0, 2'd0, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[4] = mkVec("w222",  1'b1, 2'd2, 2'd2, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[5] = mkVec("w120z", 1'b1, 2'd1, 2'd2, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[6] = mkVec("w003",  1'b1, 2'd0, 2'd0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        vecs[7] = mkVec("w120b", 1'b1, 2'd1, 2'd2, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        rst_i = 1'b1;
        setIdle();
        setRead(2'd0, 2'd0, 2'd0);
        repeat (3) tick();
        rst_i = 1'b0;
        #1;
        checkOutput("rst_busy", busy_o, 1'b0);
        checkOutput("rst_done", done_o, 1'b0);
        checkOutput("rst_wr_err", wr_err_o, 1'b0);
        checkOutput("rst_rd_data", rd_data_o, 1'b0);
        checkOutput("rst_rd_err", rd_err_o, 1'b0);
        checkOutput("rst_wr_ready", wr_ready_o, 1'b1);
        readCheck(2'd1, 2'd2, 2'd0, 1'b0, 1'b0, "rst_rd120");

        $display("[TB] single write vectors");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].wr, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d, 1'b0, 1'b0, 1'b0);
            setRead(vecs[i].a, vecs[i].b, vecs[i].c);
            #1;
            checkOutput({vecs[i].name, "_ready"}, wr_ready_o, 1'b1);
            tick();
            if (vecs[i].wr && vecs[i].a < 2'd3 && vecs[i].b < 2'd3 && vecs[i].c < 2'd3)
                model[int'(vecs[i].a) * 9 + int'(vecs[i].b) * 3 + int'(vecs[i].c)] = vecs[i].d;
            checkOutput({vecs[i].name, "_old"}, rd_data_o, vecs[i].expOld);
            checkOutput({vecs[i].name, "_err1"}, rd_err_o, vecs[i].expErr);
            checkOutput({vecs[i].name, "_wr_err"}, wr_err_o, vecs[i].expWrErr);
            setIdle();
            tick();
            checkOutput({vecs[i].name, "_new"}, rd_data_o, vecs[i].expNew);
            checkOutput({vecs[i].name, "_err2"}, rd_err_o, vecs[i].expErr);
            checkOutput({vecs[i].name, "_wr_err_clr"}, wr_err_o, 1'b0);
        end
        sweepCheck("sweep_single");

        $display("[TB] parity burst with stall");
        runBurst(8, 0, "bpar");
        readCheck(2'd2, 2'd1, 2'd1, 1'b0, 1'b0, "bpar_rd211");
        readCheck(2'd1, 2'd0, 2'd2, 1'b1, 1'b0, "bpar_rd102");
        sweepCheck("sweep_par");

        $display("[TB] ones burst then clear over burst_go");
        runBurst(-1, 1, "bone");
        readCheck(2'd2, 2'd2, 2'd2, 1'b1, 1'b0, "bone_rd222");
        runClear(-1, "clr");
        sweepCheck("sweep_clr");

        $display("[TB] burst abort");
        applyStimulus(1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("abort_go_busy", busy_o, 1'b1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 2'd2, 2'd2, 2'd2, 1'b1, 1'b0, (i == 4) ? 1'b1 : 1'b0, 1'b0);
            tick();
            model[i] = 1'b1;
            checkOutput($sformatf("abort_done%0d", i), done_o, 1'b0);
        end
        checkOutput("abort_busy", busy_o, 1'b0);
        setIdle();
        #1;
        checkOutput("abort_idle_ready", wr_ready_o, 1'b1);
        tick();
        checkOutput("abort_done_after", done_o, 1'b0);
        readCheck(2'd0, 2'd1, 2'd1, 1'b1, 1'b0, "abort_rd011");
        readCheck(2'd0, 2'd1, 2'd2, 1'b0, 1'b0, "abort_rd012");
        sweepCheck("sweep_abort");

        $display("[TB] reset during clear");
        runBurst(-1, 1, "bone2");
        runClear(10, "clrrst");
        sweepCheck("sweep_rst");

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
